// File: rtl/burst_ram_arbiter.sv
// burst_ram_arbiter: shares one burst-RAM controller port between an
// instruction-fetch requester (A) and a data requester (B). Traffic is held
// off until the controller reports calibration. One whole burst is granted at
// a time, round robin on ties, and each burst ends with a done pulse on the
// granted port.
`timescale 1ns/1ps
module burst_ram_arbiter #(
  parameter int ADDRESS_BITWIDTH = 32,
  parameter int DATA_BITWIDTH    = 64,
  parameter int BURST_DATA_COUNT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  // burst-RAM controller side
  input  logic                        br_init_calib,
  input  logic                        br_busy,
  output logic                        br_cmd,
  output logic                        br_cmd_en,
  output logic [ADDRESS_BITWIDTH-1:0] br_addr,
  output logic [DATA_BITWIDTH-1:0]    br_wr_data,
  input  logic [DATA_BITWIDTH-1:0]    br_rd_data,
  input  logic                        br_data_ready,
  // port A (instruction fetch)
  input  logic                        a_req,
  input  logic                        a_cmd,
  input  logic [ADDRESS_BITWIDTH-1:0] a_addr,
  input  logic [DATA_BITWIDTH-1:0]    a_wr_data,
  output logic                        a_wr_next,
  output logic [DATA_BITWIDTH-1:0]    a_rd_data,
  output logic                        a_rd_valid,
  output logic                        a_done,
  // port B (data access)
  input  logic                        b_req,
  input  logic                        b_cmd,
  input  logic [ADDRESS_BITWIDTH-1:0] b_addr,
  input  logic [DATA_BITWIDTH-1:0]    b_wr_data,
  output logic                        b_wr_next,
  output logic [DATA_BITWIDTH-1:0]    b_rd_data,
  output logic                        b_rd_valid,
  output logic                        b_done,
  // status
  output logic                        ready
);

  // One extra bit so a read burst can count up to BURST_DATA_COUNT itself
  // and sit there while the final word drains, without wrapping.
  localparam int CNT_W = $clog2(BURST_DATA_COUNT) + 1;
  localparam logic [CNT_W-1:0] LAST_WR_WORD = CNT_W'(BURST_DATA_COUNT - 1);
  localparam logic [CNT_W-1:0] ALL_WORDS    = CNT_W'(BURST_DATA_COUNT);

  typedef enum logic [2:0] {
    S_INIT,
    S_READY,
    S_WRITE,
    S_READ,
    S_DONE
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  state_t                      state_q;
  state_t                      state_d;
  port_t                       last_grant;
  logic [CNT_W-1:0]            word_cnt;

  logic                        grant_en;
  port_t                       grant_port;
  logic                        grant_cmd;
  logic [ADDRESS_BITWIDTH-1:0] grant_addr;
  port_t                       data_port;
  logic [DATA_BITWIDTH-1:0]    wr_word;
  logic                        wr_next;
  logic                        rd_take;

  // Arbitration and data steering: who wins this cycle, and which port's
  // write word feeds the RAM (the winner in the grant cycle, else the owner).
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    grant_en   = 1'b0;
    grant_port = PORT_A;
    if (state_q == S_READY && br_init_calib && !br_busy && (a_req || b_req)) begin
      grant_en = 1'b1;
      // B wins when alone, or on a tie when A had the previous burst.
      if (b_req && (!a_req || last_grant == PORT_A)) begin
        grant_port = PORT_B;
      end
    end
    grant_cmd  = (grant_port == PORT_B) ? b_cmd  : a_cmd;
    grant_addr = (grant_port == PORT_B) ? b_addr : a_addr;
    data_port  = grant_en ? grant_port : last_grant;
    wr_word    = (data_port == PORT_B) ? b_wr_data : a_wr_data;
    wr_next    = (grant_en && grant_cmd) || (state_q == S_WRITE);
  end

  // A read word is accepted only while the burst still needs words.
  assign rd_take = (state_q == S_READ) && br_data_ready && (word_cnt < ALL_WORDS);

  // Next-state logic for the burst sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (br_init_calib) state_d = S_READY;
      S_READY: begin
        if (!br_init_calib) begin
          state_d = S_INIT;
        end else if (grant_en) begin
          state_d = grant_cmd ? S_WRITE : S_READ;
        end
      end
      // Calibration loss is not looked at mid-burst; the burst always ends.
      S_WRITE: if (word_cnt == LAST_WR_WORD) state_d = S_DONE;
      // Leave one cycle after the last word so done trails its rd_valid.
      S_READ:  if (word_cnt == ALL_WORDS) state_d = S_DONE;
      S_DONE:  state_d = S_READY;
      default: state_d = S_INIT;
    endcase
  end

  // State register, grant history and word counter.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= S_INIT;
      last_grant <= PORT_B;
      word_cnt   <= '0;
    end else begin
      state_q <= state_d;
      if (grant_en) begin
        last_grant <= grant_port;
        // Word 0 of a write is taken in the grant cycle itself.
        word_cnt   <= grant_cmd ? CNT_W'(1) : '0;
      end else if (state_q == S_WRITE || rd_take) begin
        word_cnt <= word_cnt + CNT_W'(1);
      end
    end
  end

  // Command strobe, command, address and write-word registers toward the RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cmd_en  <= 1'b0;
      br_cmd     <= 1'b0;
      br_addr    <= '0;
      br_wr_data <= '0;
    end else begin
      br_cmd_en <= grant_en;
      if (grant_en) begin
        br_cmd  <= grant_cmd;
        br_addr <= grant_addr;
      end
      if (wr_next) begin
        br_wr_data <= wr_word;
      end
    end
  end

  // Read-return registers: only the burst owner's data and valid move.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rd_data  <= '0;
      a_rd_valid <= 1'b0;
      b_rd_data  <= '0;
      b_rd_valid <= 1'b0;
    end else begin
      a_rd_valid <= rd_take && (last_grant == PORT_A);
      b_rd_valid <= rd_take && (last_grant == PORT_B);
      if (rd_take && last_grant == PORT_A) a_rd_data <= br_rd_data;
      if (rd_take && last_grant == PORT_B) b_rd_data <= br_rd_data;
    end
  end

  assign a_wr_next = wr_next && (data_port == PORT_A);
  assign b_wr_next = wr_next && (data_port == PORT_B);
  assign a_done    = (state_q == S_DONE) && (last_grant == PORT_A);
  assign b_done    = (state_q == S_DONE) && (last_grant == PORT_B);
  assign ready     = (state_q == S_READY);

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// tb_burst_ram_arbiter: directed stimulus for burst_ram_arbiter with a
// scoreboard of expected commands, write words, read words and done pulses,
// plus a simple burst-RAM responder.
`timescale 1ns/1ps
module tb_burst_ram_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int N  = 4;

  logic          clk;
  logic          rst;
  logic          br_init_calib;
  logic          br_busy;
  logic          br_cmd;
  logic          br_cmd_en;
  logic [AW-1:0] br_addr;
  logic [DW-1:0] br_wr_data;
  logic [DW-1:0] br_rd_data;
  logic          br_data_ready;
  logic          a_req, a_cmd, a_wr_next, a_rd_valid, a_done;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wr_data, a_rd_data;
  logic          b_req, b_cmd, b_wr_next, b_rd_valid, b_done;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wr_data, b_rd_data;
  logic          ready;

  burst_ram_arbiter #(
    .ADDRESS_BITWIDTH(AW),
    .DATA_BITWIDTH   (DW),
    .BURST_DATA_COUNT(N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .br_init_calib(br_init_calib),
    .br_busy      (br_busy),
    .br_cmd       (br_cmd),
    .br_cmd_en    (br_cmd_en),
    .br_addr      (br_addr),
    .br_wr_data   (br_wr_data),
    .br_rd_data   (br_rd_data),
    .br_data_ready(br_data_ready),
    .a_req        (a_req),
    .a_cmd        (a_cmd),
    .a_addr       (a_addr),
    .a_wr_data    (a_wr_data),
    .a_wr_next    (a_wr_next),
    .a_rd_data    (a_rd_data),
    .a_rd_valid   (a_rd_valid),
    .a_done       (a_done),
    .b_req        (b_req),
    .b_cmd        (b_cmd),
    .b_addr       (b_addr),
    .b_wr_data    (b_wr_data),
    .b_wr_next    (b_wr_next),
    .b_rd_data    (b_rd_data),
    .b_rd_valid   (b_rd_valid),
    .b_done       (b_done),
    .ready        (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic          cmd;
    logic [AW-1:0] addr;
  } cmd_exp_t;

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
  } rd_exp_t;

  cmd_exp_t      exp_cmd_q[$];
  rd_exp_t       exp_rd_q[$];
  logic [DW-1:0] exp_wr_q[$];
  logic          exp_done_q[$];

  int n_assert = 0;
  int n_fail   = 0;
  int n_cmd    = 0;
  int a_valid_cnt = 0;
  int a_wn = 0;
  int b_wn = 0;
  int rd_gap = 0;
  bit extra_pulse = 0;

  logic [DW-1:0] a_words[N];
  logic [DW-1:0] b_words[N];

  logic outs_zero;
  assign outs_zero = ({br_cmd_en, br_cmd, br_addr, br_wr_data,
                       a_wr_next, a_rd_data, a_rd_valid, a_done,
                       b_wr_next, b_rd_data, b_rd_valid, b_done, ready} === '0);

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Read words the RAM model returns; address 0x40 yields 0x11,0x22,0x33,0x44.
  function automatic logic [DW-1:0] rd_word(input logic [AW-1:0] addr, input int i);
    return {addr - 32'h40, 32'((i + 1) * 32'h11)};
  endfunction

  task automatic exp_read(input logic port, input logic [AW-1:0] addr);
    cmd_exp_t c;
    rd_exp_t  r;
    c.cmd  = 1'b0;
    c.addr = addr;
    exp_cmd_q.push_back(c);
    for (int i = 0; i < N; i++) begin
      r.port = port;
      r.data = rd_word(addr, i);
      exp_rd_q.push_back(r);
    end
    exp_done_q.push_back(port);
  endtask

  task automatic exp_write(input logic port, input logic [AW-1:0] addr);
    cmd_exp_t c;
    c.cmd  = 1'b1;
    c.addr = addr;
    exp_cmd_q.push_back(c);
    for (int i = 0; i < N; i++) exp_wr_q.push_back(port ? b_words[i] : a_words[i]);
    exp_done_q.push_back(port);
  endtask

  // ---------------- output monitor ----------------
  initial begin
    cmd_exp_t ec;
    rd_exp_t  er;
    logic     ed;
    logic     prev_cmd_en;
    int       wr_left;
    prev_cmd_en = 1'b0;
    wr_left     = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_cmd_en = 1'b0;
        wr_left     = 0;
      end else begin
        if (br_cmd_en) begin
          n_cmd++;
          check("cmd_en_single_cycle", prev_cmd_en, 1'b0);
          check("cmd_expected", exp_cmd_q.size() > 0, 1'b1);
          if (exp_cmd_q.size() > 0) begin
            ec = exp_cmd_q.pop_front();
            check("cmd_rw", br_cmd, ec.cmd);
            check("cmd_addr", br_addr, ec.addr);
            if (ec.cmd) wr_left = N;
          end
        end
        prev_cmd_en = br_cmd_en;
        if (wr_left > 0) begin
          check("wr_expected", exp_wr_q.size() > 0, 1'b1);
          if (exp_wr_q.size() > 0) check("wr_data", br_wr_data, exp_wr_q.pop_front());
          wr_left--;
        end
        if (a_rd_valid || b_rd_valid) begin
          check("rd_valid_exclusive", a_rd_valid & b_rd_valid, 1'b0);
          check("rd_expected", exp_rd_q.size() > 0, 1'b1);
          if (exp_rd_q.size() > 0) begin
            er = exp_rd_q.pop_front();
            check("rd_port", b_rd_valid, er.port);
            check("rd_data", b_rd_valid ? b_rd_data : a_rd_data, er.data);
          end
          if (a_rd_valid) a_valid_cnt++;
        end
        if (a_done || b_done) begin
          check("done_exclusive", a_done & b_done, 1'b0);
          check("done_expected", exp_done_q.size() > 0, 1'b1);
          if (exp_done_q.size() > 0) begin
            ed = exp_done_q.pop_front();
            check("done_port", b_done, ed);
          end
        end
      end
    end
  end

  // ---------------- burst-RAM read responder ----------------
  initial begin
    logic [AW-1:0] addr;
    br_data_ready = 1'b0;
    br_rd_data    = '0;
    forever begin
      @(negedge clk);
      if (!rst && br_cmd_en && !br_cmd) begin
        addr = br_addr;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
          for (int g = 0; g < rd_gap; g++) begin
            #1 br_data_ready = 1'b0;
            @(posedge clk);
          end
          #1;
          if (rst) break;
          br_data_ready = 1'b1;
          br_rd_data    = rd_word(addr, i);
          @(posedge clk);
        end
        #1 br_data_ready = 1'b0;
        if (extra_pulse && !rst) begin
          // Stray strobes after the burst must be ignored by the arbiter.
          br_data_ready = 1'b1;
          br_rd_data    = 64'hDEAD_BEEF_DEAD_BEEF;
          repeat (2) @(posedge clk);
          #1 br_data_ready = 1'b0;
        end
      end
    end
  end

  // ---------------- requester engine ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold each port's request until it has completed the given number of
  // bursts, advancing write words on wr_next and dropping req after done.
  task automatic run(input int na, input int nb, input int max_cycles);
    int   da, db, cyc, ia, ib;
    logic sa_next, sb_next, sa_done, sb_done;
    da = 0; db = 0; cyc = 0; ia = 0; ib = 0;
    a_req = (na > 0);
    b_req = (nb > 0);
    while ((da < na || db < nb) && cyc < max_cycles) begin
      @(negedge clk);
      sa_next = a_wr_next;
      sb_next = b_wr_next;
      sa_done = a_done;
      sb_done = b_done;
      tick();
      cyc++;
      if (sa_next) begin
        a_wn++;
        ia++;
        if (ia < N) a_wr_data = a_words[ia];
      end
      if (sb_next) begin
        b_wn++;
        ib++;
        if (ib < N) b_wr_data = b_words[ib];
      end
      if (sa_done) begin
        da++;
        ia = 0;
        a_wr_data = a_words[0];
        if (da >= na) a_req = 1'b0;
      end
      if (sb_done) begin
        db++;
        ib = 0;
        b_wr_data = b_words[0];
        if (db >= nb) b_req = 1'b0;
      end
    end
    check("run_bursts_completed", {32'(da), 32'(db)}, {32'(na), 32'(nb)});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int got;
    int cyc;
    int base;

    rst = 1'b1;
    br_init_calib = 1'b0;
    br_busy = 1'b0;
    a_req = 1'b0; a_cmd = 1'b0; a_addr = '0; a_wr_data = '0;
    b_req = 1'b0; b_cmd = 1'b0; b_addr = '0; b_wr_data = '0;
    for (int i = 0; i < N; i++) begin
      a_words[i] = 64'h1000 + 64'(i);
      b_words[i] = 64'hA0 + 64'(i);
    end

    // 1. reset and calibration
    repeat (3) tick();
    check("reset_outputs_zero", outs_zero, 1'b1);
    rst = 1'b0;
    repeat (50) tick();
    check("uncalibrated_outputs_zero", outs_zero, 1'b1);
    check("uncalibrated_ready", ready, 1'b0);
    br_init_calib = 1'b1;
    @(negedge clk);
    check("ready_same_cycle_as_calib", ready, 1'b0);
    tick();
    @(negedge clk);
    check("ready_after_calib", ready, 1'b1);
    tick();

    // 2. A read at 0x40, with request-to-command latency
    exp_read(1'b0, 32'h40);
    a_cmd = 1'b0; a_addr = 32'h40; a_req = 1'b1;
    @(negedge clk);
    check("lat_grant_cycle_cmd_en", br_cmd_en, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("lat_cmd_en_after_1", br_cmd_en, 1'b1);
    run(1, 0, 200);
    repeat (3) tick();
    check("a_rd_data_last", a_rd_data, 64'h44);
    check("b_rd_data_untouched", b_rd_data, 64'h0);

    // 3. B write of A0..A3 at 0x80
    a_wn = 0; b_wn = 0;
    b_cmd = 1'b1; b_addr = 32'h80; b_wr_data = b_words[0];
    exp_write(1'b1, 32'h80);
    run(0, 1, 200);
    check("b_wr_next_pulses", b_wn, 4);
    check("a_wr_next_pulses", a_wn, 0);
    check("a_rd_data_holds", a_rd_data, 64'h44);
    repeat (2) tick();

    // 4. round robin: both hold req for two bursts each -> A,B,A,B
    a_cmd = 1'b0; a_addr = 32'h100;
    b_cmd = 1'b0; b_addr = 32'h200;
    exp_read(1'b0, 32'h100);
    exp_read(1'b1, 32'h200);
    exp_read(1'b0, 32'h100);
    exp_read(1'b1, 32'h200);
    run(2, 2, 600);
    repeat (2) tick();
    check("rr_a_rd_data", a_rd_data, rd_word(32'h100, N - 1));
    check("rr_b_rd_data", b_rd_data, rd_word(32'h200, N - 1));

    // 5. busy hold-off, then gapped read data with stray strobes
    br_busy = 1'b1;
    a_cmd = 1'b0; a_addr = 32'h300; a_req = 1'b1;
    base = n_cmd;
    repeat (20) tick();
    check("busy_no_cmd_en", n_cmd, base);
    check("busy_still_ready", ready, 1'b1);
    exp_read(1'b0, 32'h300);
    rd_gap = 3;
    extra_pulse = 1'b1;
    base = a_valid_cnt;
    br_busy = 1'b0;
    run(1, 0, 400);
    repeat (4) tick();
    check("gapped_rd_valid_count", a_valid_cnt - base, 4);
    check("stray_strobe_ignored", a_rd_data, rd_word(32'h300, N - 1));
    rd_gap = 0;
    extra_pulse = 1'b0;

    // calibration loss while idle
    br_init_calib = 1'b0;
    tick();
    @(negedge clk);
    check("calib_loss_ready", ready, 1'b0);
    br_init_calib = 1'b1;
    tick();
    @(negedge clk);
    check("recalib_ready", ready, 1'b1);
    tick();

    // 6. reset after the second read word, then a fresh burst
    exp_read(1'b0, 32'h400);
    a_cmd = 1'b0; a_addr = 32'h400; a_req = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 2 && cyc < 100) begin
      @(negedge clk);
      if (a_rd_valid) got++;
      cyc++;
    end
    check("mid_burst_second_word_seen", got, 2);
    rst = 1'b1;
    a_req = 1'b0;
    br_init_calib = 1'b0;
    #1;
    check("mid_burst_reset_outputs_zero", outs_zero, 1'b1);
    exp_rd_q.delete();
    exp_done_q.delete();
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    check("post_reset_not_ready", ready, 1'b0);
    br_init_calib = 1'b1;
    tick();
    @(negedge clk);
    check("post_reset_ready", ready, 1'b1);
    tick();
    exp_read(1'b0, 32'h500);
    a_addr = 32'h500;
    run(1, 0, 200);
    repeat (3) tick();
    check("fresh_burst_rd_data", a_rd_data, rd_word(32'h500, N - 1));

    check("scoreboard_drained",
          64'(exp_cmd_q.size() + exp_rd_q.size() + exp_wr_q.size() + exp_done_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
